util_distdemux: RTL and testbench
=================================

Name: util_distdemux

Overview:
- Seamless packet demultiplexer; the distribution counterpart of the channel packet multiplexer in facc_5g/pack.
- Accepts one sop/eop/valid/data/empty packet stream.
- Selects one destination channel per packet at sop, either from a destination field or by round robin over ready channels.
- Holds that selection until eop and replicates beats onto the selected channel's strobes. Packets with no usable destination are dropped and flagged.

Parameters:
- DATA_WIDTH, 64, data bit width.
- EMPT_WIDTH, BIT_WIDTH(DATA_WIDTH/8-1), empty bit width; port width is 1 when 0.
- CHANNEL_QTY, 6, output channel quantity, minimum 1.
- DEST_WIDTH, 3, din_dest width, ≥ ceil(log2(CHANNEL_QTY)), minimum 1.
- DEST_MODE, 0, '0' = channel from din_dest at sop; '1' = round robin over chan_ready.
- INDX_WIDTH, 10, dout_index bit width.

Ports:
- clk_arbit  in  1  clock, posedge active
- rst_n  in  1  reset, asynchronous, active-low
- din_sop  in  1  input start of packet
- din_eop  in  1  input end of packet
- din_valid  in  1  input beat valid; sop/eop qualified by it
- din_data  in  DATA_WIDTH  input data
- din_empty  in  EMPT_WIDTH  input empty bytes
- din_dest  in  DEST_WIDTH  destination channel, sampled on sop beat (DEST_MODE=0)
- chan_ready  in  CHANNEL_QTY  per-channel can-accept-packet, sampled on sop beat only
- dout_sop  out  CHANNEL_QTY  per-channel start of packet
- dout_eop  out  CHANNEL_QTY  per-channel end of packet
- dout_valid  out  CHANNEL_QTY  per-channel beat valid
- dout_data  out  DATA_WIDTH  shared output data, qualified by dout_valid
- dout_empty  out  EMPT_WIDTH  shared output empty
- dout_grant  out  CHANNEL_QTY  one-hot channel owning current packet
- dout_index  out  INDX_WIDTH  beat index within packet, 0 on sop beat
- drop_pulse  out  1  one cycle per dropped packet (on its sop beat)
- err_pulse  out  1  one cycle per protocol error

Behaviour:
- All outputs registered; latency exactly 1 cycle from din beat to dout beat. No backpressure; din is never stalled.
- Reset: all outputs 0, state IDLE, grant 0, RR pointer = CHANNEL_QTY-1 (first RR grant is channel 0). Reset mid-packet abandons the packet; no eop is emitted.
- States: IDLE (no packet), PASS (forwarding to grant), DROP (discarding to eop).
- Decision on any din_valid&din_sop beat, in any state:
  - DEST_MODE=0: target = din_dest. Drop if din_dest ≥ CHANNEL_QTY or chan_ready[din_dest]=0.
  - DEST_MODE=1: first ready channel strictly after the RR pointer, wrapping. Drop if chan_ready=0. Pointer updates only on grant, never on drop.
  - Grant: the beat is forwarded, grant latched, state PASS. Drop: drop_pulse=1, state DROP.
- PASS: every valid beat drives dout_valid[g], with dout_sop[g]/dout_eop[g] copied; data/empty registered.
- PASS, on a valid eop beat: beat forwarded, then IDLE. dout_grant clears the cycle after dout_eop.
- DROP: beats discarded; eop returns to IDLE.
- sop&eop in one beat: single-beat packet, decided and completed; state stays IDLE.
- sop in PASS/DROP before eop: err_pulse=1. The previous packet is abandoned without eop and the new sop is decided normally.
- Valid non-sop beat in IDLE: discarded, err_pulse=1.
- din_valid=0: all dout strobes 0. dout_data/dout_empty hold their last value.
- dout_index: 0 on sop beat, +1 per forwarded beat, saturates at all-ones; held otherwise.

Optional Feature:
- Macro UTIL_DISTDEMUX_STAT_EN.
- Defined: adds outputs stat_pkt [31:0] (granted packets), stat_drop [31:0] (dropped packets) and stat_err [31:0] (err_pulse count). Counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package util_pack_pkg: state enum (IDLE/PASS/DROP), BIT_WIDTH function, and the DEST_MODE_FIELD=0 / DEST_MODE_RR=1 constants.
- One sub-module util_rr_pick: combinational next-ready-after-pointer one-hot picker (request vector and pointer in, one-hot grant and found flag out). Reusable by the mux-side arbiter.

Test Plan:
- DEST_MODE=0, chan_ready=6'h3F, 4-beat packet with din_dest=2 → dout_valid[2] for 4 cycles starting 1 cycle later; dout_sop[2] on first, dout_eop[2] on last; dout_index 0..3; dout_grant=6'h04 then 0.
- DEST_MODE=0: din_dest=7 → drop_pulse once, no dout_valid. Separately din_dest=1 with chan_ready[1]=0 → drop_pulse once, no dout_valid.
- DEST_MODE=1, chan_ready=6'b101010, three back-to-back 2-beat packets after reset → grants to channels 1, 3, 5; a fourth packet → channel 1.
- Single-beat packet (sop=eop=1) to channel 0 → dout_sop[0]=dout_eop[0]=dout_valid[0]=1 for one cycle; state remains IDLE.
- sop on channel 2, second sop before eop with dest 4 → err_pulse=1, channel 2 gets no eop, rest routed to channel 4. A valid non-sop beat in IDLE → err_pulse=1 with no dout_valid.
- rst_n asserted mid-packet → all outputs 0 asynchronously. After release, remaining beats without sop raise err_pulse; RR restarts at channel 0. With UTIL_DISTDEMUX_STAT_EN, all counters read 0.

Source files
------------

// File: rtl/util_pack_pkg.sv
// Shared types and helpers for the packet mux/demux utilities.
package util_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int DEST_MODE_FIELD = 0;
  localparam int DEST_MODE_RR    = 1;

  // Bits needed to represent value; 0 for value 0.
  function automatic int BIT_WIDTH(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if (value >= (1 << i)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/util_rr_pick.sv
// Combinational picker: first requesting channel strictly after the pointer, wrapping.
module util_rr_pick #(
  parameter int N  = 6,
  parameter int PW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  logic [PW-1:0] w_c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_c     = '0;
    // Offset N is the pointer itself, so it is considered last.
    for (int k = 1; k <= N; k++) begin
      w_c = PW'((int'(i_ptr) + k) % N);
      if (!o_found && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
        o_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/util_distdemux.sv
// Packet demultiplexer: routes each packet to one channel chosen at sop.
// Optional statistics counters enabled with UTIL_DISTDEMUX_STAT_EN.
module util_distdemux
  import util_pack_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPT_WIDTH  = BIT_WIDTH(DATA_WIDTH/8-1),
  parameter int CHANNEL_QTY = 6,
  parameter int DEST_WIDTH  = 3,
  parameter int DEST_MODE   = 0,
  parameter int INDX_WIDTH  = 10
) (
  input  logic                                     clk_arbit,
  input  logic                                     rst_n,
  input  logic                                     din_sop,
  input  logic                                     din_eop,
  input  logic                                     din_valid,
  input  logic [DATA_WIDTH-1:0]                    din_data,
  input  logic [(EMPT_WIDTH>0?EMPT_WIDTH:1)-1:0]   din_empty,
  input  logic [DEST_WIDTH-1:0]                    din_dest,
  input  logic [CHANNEL_QTY-1:0]                   chan_ready,
  output logic [CHANNEL_QTY-1:0]                   dout_sop,
  output logic [CHANNEL_QTY-1:0]                   dout_eop,
  output logic [CHANNEL_QTY-1:0]                   dout_valid,
  output logic [DATA_WIDTH-1:0]                    dout_data,
  output logic [(EMPT_WIDTH>0?EMPT_WIDTH:1)-1:0]   dout_empty,
  output logic [CHANNEL_QTY-1:0]                   dout_grant,
  output logic [INDX_WIDTH-1:0]                    dout_index,
  output logic                                     drop_pulse,
  output logic                                     err_pulse,
  output logic [1:0]                               dbg_state
`ifdef UTIL_DISTDEMUX_STAT_EN
  ,
  output logic [31:0]                              stat_pkt,
  output logic [31:0]                              stat_drop,
  output logic [31:0]                              stat_err
`endif
);

  localparam int EW = (EMPT_WIDTH > 0) ? EMPT_WIDTH : 1;
  localparam int PW = (BIT_WIDTH(CHANNEL_QTY-1) > 0) ? BIT_WIDTH(CHANNEL_QTY-1) : 1;

  state_e                   r_state;
  logic [PW-1:0]            r_ptr;
  logic [CHANNEL_QTY-1:0]   r_sop, r_eop, r_valid, r_grant;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [EW-1:0]            r_empty;
  logic [INDX_WIDTH-1:0]    r_index;
  logic                     r_drop, r_err;

  logic [CHANNEL_QTY-1:0]   w_field_gnt, w_rr_gnt, w_tgt;
  logic [PW-1:0]            w_rr_idx;
  logic                     w_rr_found, w_found;
  logic                     w_is_sop, w_err, w_grant_ev, w_drop_ev;

  util_rr_pick #(.N(CHANNEL_QTY), .PW(PW)) u_rr_pick (
    .i_req   (chan_ready),
    .i_ptr   (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  // Field mode: an out-of-range destination matches no channel and is dropped.
  always_comb begin
    w_field_gnt = '0;
    for (int i = 0; i < CHANNEL_QTY; i++) begin
      w_field_gnt[i] = (din_dest == DEST_WIDTH'(i)) && chan_ready[i];
    end
  end

  assign w_tgt      = (DEST_MODE == DEST_MODE_RR) ? w_rr_gnt : w_field_gnt;
  assign w_found    = (DEST_MODE == DEST_MODE_RR) ? w_rr_found : (|w_field_gnt);
  assign w_is_sop   = din_valid && din_sop;
  assign w_grant_ev = w_is_sop && w_found;
  assign w_drop_ev  = w_is_sop && !w_found;
  assign w_err      = (w_is_sop && (r_state != IDLE)) ||
                      (din_valid && !din_sop && (r_state == IDLE));

  always_ff @(posedge clk_arbit or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= PW'(CHANNEL_QTY-1);
      r_sop   <= '0;
      r_eop   <= '0;
      r_valid <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_empty <= '0;
      r_index <= '0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sop   <= '0;
      r_eop   <= '0;
      r_valid <= '0;
      r_drop  <= w_drop_ev;
      r_err   <= w_err;
      // Grant stays visible through the eop beat, then clears.
      if (r_state != PASS) r_grant <= '0;
      if (w_is_sop) begin
        if (w_found) begin
          r_valid <= w_tgt;
          r_sop   <= w_tgt;
          r_eop   <= {CHANNEL_QTY{din_eop}} & w_tgt;
          r_grant <= w_tgt;
          r_data  <= din_data;
          r_empty <= din_empty;
          r_index <= '0;
          r_state <= din_eop ? IDLE : PASS;
          if (DEST_MODE == DEST_MODE_RR) r_ptr <= w_rr_idx;
        end else begin
          r_grant <= '0;
          r_state <= din_eop ? IDLE : DROP;
        end
      end else if (din_valid) begin
        case (r_state)
          PASS: begin
            r_valid <= r_grant;
            r_eop   <= {CHANNEL_QTY{din_eop}} & r_grant;
            r_data  <= din_data;
            r_empty <= din_empty;
            r_index <= (&r_index) ? r_index : r_index + 1'b1;
            if (din_eop) r_state <= IDLE;
          end
          DROP: begin
            if (din_eop) r_state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout_sop   = r_sop;
  assign dout_eop   = r_eop;
  assign dout_valid = r_valid;
  assign dout_data  = r_data;
  assign dout_empty = r_empty;
  assign dout_grant = r_grant;
  assign dout_index = r_index;
  assign drop_pulse = r_drop;
  assign err_pulse  = r_err;
  assign dbg_state  = r_state;

`ifdef UTIL_DISTDEMUX_STAT_EN
  logic [31:0] r_stat_pkt, r_stat_drop, r_stat_err;

  always_ff @(posedge clk_arbit or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pkt  <= '0;
      r_stat_drop <= '0;
      r_stat_err  <= '0;
    end else begin
      if (w_grant_ev) r_stat_pkt  <= r_stat_pkt + 32'd1;
      if (w_drop_ev)  r_stat_drop <= r_stat_drop + 32'd1;
      if (w_err)      r_stat_err  <= r_stat_err + 32'd1;
    end
  end

  assign stat_pkt  = r_stat_pkt;
  assign stat_drop = r_stat_drop;
  assign stat_err  = r_stat_err;
`endif

endmodule

// File: tb/tb_util_distdemux.sv
// Bench for util_distdemux: field-mode and round-robin instances fed the same stream.
module tb_util_distdemux;

  localparam int NC = 6;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int IW = 10;

  typedef struct packed {
    logic [NC-1:0] sop;
    logic [NC-1:0] eop;
    logic [NC-1:0] valid;
    logic [NC-1:0] grant;
    logic          drop;
    logic          err;
    logic [1:0]    st;
    logic          chk;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic clk_arbit = 1'b0;
  logic rst_n     = 1'b0;
  logic din_sop   = 1'b0;
  logic din_eop   = 1'b0;
  logic din_valid = 1'b0;
  logic [DW-1:0] din_data  = '0;
  logic [EW-1:0] din_empty = '0;
  logic [2:0]    din_dest  = '0;
  logic [NC-1:0] chan_ready = '1;

  logic [NC-1:0] sop_f, eop_f, valid_f, grant_f, sop_r, eop_r, valid_r, grant_r;
  logic [DW-1:0] data_f, data_r;
  logic [EW-1:0] empty_f, empty_r;
  logic [IW-1:0] index_f, index_r;
  logic          drop_f, drop_r, err_f, err_r;
  logic [1:0]    st_f, st_r;
`ifdef UTIL_DISTDEMUX_STAT_EN
  logic [31:0]   spkt_f, sdrop_f, serr_f, spkt_r, sdrop_r, serr_r;
`endif

  util_distdemux #(.DEST_MODE(0)) u_dut_f (
    .clk_arbit(clk_arbit), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop),
    .din_valid(din_valid), .din_data(din_data), .din_empty(din_empty), .din_dest(din_dest),
    .chan_ready(chan_ready), .dout_sop(sop_f), .dout_eop(eop_f), .dout_valid(valid_f),
    .dout_data(data_f), .dout_empty(empty_f), .dout_grant(grant_f), .dout_index(index_f),
    .drop_pulse(drop_f), .err_pulse(err_f), .dbg_state(st_f)
`ifdef UTIL_DISTDEMUX_STAT_EN
    , .stat_pkt(spkt_f), .stat_drop(sdrop_f), .stat_err(serr_f)
`endif
  );

  util_distdemux #(.DEST_MODE(1)) u_dut_r (
    .clk_arbit(clk_arbit), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop),
    .din_valid(din_valid), .din_data(din_data), .din_empty(din_empty), .din_dest(din_dest),
    .chan_ready(chan_ready), .dout_sop(sop_r), .dout_eop(eop_r), .dout_valid(valid_r),
    .dout_data(data_r), .dout_empty(empty_r), .dout_grant(grant_r), .dout_index(index_r),
    .drop_pulse(drop_r), .err_pulse(err_r), .dbg_state(st_r)
`ifdef UTIL_DISTDEMUX_STAT_EN
    , .stat_pkt(spkt_r), .stat_drop(sdrop_r), .stat_err(serr_r)
`endif
  );

  // Clock / reset
  always #5 clk_arbit = ~clk_arbit;

  // Scoreboard state
  logic [W-1:0] exp_q_f[$];
  logic [W-1:0] exp_q_r[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = field mode, 1 = round robin
  int m_st[2], m_ch[2], m_ptr[2], m_pkt[2], m_drop[2], m_errc[2];
  logic [IW-1:0] m_idx[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_ch[m] = 0; m_ptr[m] = NC - 1; m_idx[m] = '0;
      m_pkt[m] = 0; m_drop[m] = 0; m_errc[m] = 0;
    end
  endtask

  // Predicts the registered outputs produced from the beat now on the inputs.
  task automatic model_step(input int m, output exp_t e);
    int tgt, c, d;
    e = '0;
    e.grant = (m_st[m] == 1) ? NC'(1 << m_ch[m]) : '0;
    if (din_valid && din_sop) begin
      e.err = (m_st[m] != 0);
      tgt = -1;
      d = int'(din_dest);
      if (m == 0) begin
        if (d < NC && chan_ready[d[2:0]]) tgt = d;
      end else begin
        for (int k = 1; k <= NC; k++) begin
          c = (m_ptr[m] + k) % NC;
          if (tgt < 0 && chan_ready[c[2:0]]) tgt = c;
        end
      end
      if (tgt >= 0) begin
        e.valid = NC'(1 << tgt);
        e.sop   = NC'(1 << tgt);
        e.eop   = din_eop ? NC'(1 << tgt) : '0;
        e.grant = NC'(1 << tgt);
        e.chk   = 1'b1;
        m_ch[m] = tgt;
        m_idx[m] = '0;
        m_st[m] = din_eop ? 0 : 1;
        m_pkt[m]++;
        if (m == 1) m_ptr[m] = tgt;
      end else begin
        e.drop  = 1'b1;
        e.grant = '0;
        m_st[m] = din_eop ? 0 : 2;
        m_drop[m]++;
      end
    end else if (din_valid) begin
      if (m_st[m] == 1) begin
        e.valid = NC'(1 << m_ch[m]);
        e.eop   = din_eop ? NC'(1 << m_ch[m]) : '0;
        e.chk   = 1'b1;
        if (m_idx[m] != '1) m_idx[m] = m_idx[m] + 1'b1;
        if (din_eop) m_st[m] = 0;
      end else if (m_st[m] == 2) begin
        if (din_eop) m_st[m] = 0;
      end else begin
        e.err = 1'b1;
      end
    end
    if (e.err) m_errc[m]++;
    e.st    = 2'(m_st[m]);
    e.idx   = m_idx[m];
    e.data  = din_data;
    e.empty = din_empty;
  endtask

  task automatic compare(input string p, input exp_t e, input logic [NC-1:0] s, eo, v, g,
                         input logic dr, er, input logic [1:0] st, input logic [IW-1:0] ix,
                         input logic [DW-1:0] dt, input logic [EW-1:0] em);
    check({p, ".sop"}, 64'(s), 64'(e.sop));
    check({p, ".eop"}, 64'(eo), 64'(e.eop));
    check({p, ".valid"}, 64'(v), 64'(e.valid));
    check({p, ".grant"}, 64'(g), 64'(e.grant));
    check({p, ".drop"}, 64'(dr), 64'(e.drop));
    check({p, ".err"}, 64'(er), 64'(e.err));
    check({p, ".state"}, 64'(st), 64'(e.st));
    if (e.chk) begin
      check({p, ".index"}, 64'(ix), 64'(e.idx));
      check({p, ".data"}, dt, e.data);
      check({p, ".empty"}, 64'(em), 64'(e.empty));
    end
  endtask

  // Driver: one input cycle, expectations pushed, outputs compared one cycle later.
  task automatic beat(input logic v, input logic s, input logic eo,
                      input logic [2:0] dest, input logic [NC-1:0] rdy);
    exp_t ef, er;
    @(negedge clk_arbit);
    din_valid = v; din_sop = s; din_eop = eo; din_dest = dest; chan_ready = rdy;
    din_data  = {$urandom, $urandom};
    din_empty = EW'($urandom_range(0, 7));
    model_step(0, ef);
    model_step(1, er);
    exp_q_f.push_back(W'(ef));
    exp_q_r.push_back(W'(er));
    @(posedge clk_arbit);
    #1;
    if (exp_q_f.size() == 0 || exp_q_r.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      ef = exp_t'(exp_q_f.pop_front());
      er = exp_t'(exp_q_r.pop_front());
      compare("f", ef, sop_f, eop_f, valid_f, grant_f, drop_f, err_f, st_f, index_f, data_f, empty_f);
      compare("r", er, sop_r, eop_r, valid_r, grant_r, drop_r, err_r, st_r, index_r, data_r, empty_r);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, ".valid_f"}, 64'(valid_f), 64'd0);
    check({p, ".sop_f"}, 64'(sop_f), 64'd0);
    check({p, ".eop_f"}, 64'(eop_f), 64'd0);
    check({p, ".grant_f"}, 64'(grant_f), 64'd0);
    check({p, ".index_f"}, 64'(index_f), 64'd0);
    check({p, ".data_f"}, data_f, 64'd0);
    check({p, ".pulse_f"}, 64'({drop_f, err_f, st_f}), 64'd0);
    check({p, ".valid_r"}, 64'(valid_r), 64'd0);
    check({p, ".grant_r"}, 64'(grant_r), 64'd0);
    check({p, ".data_r"}, data_r, 64'd0);
    check({p, ".pulse_r"}, 64'({drop_r, err_r, st_r}), 64'd0);
`ifdef UTIL_DISTDEMUX_STAT_EN
    check({p, ".stat_f"}, 64'({spkt_f, sdrop_f}) | 64'(serr_f), 64'd0);
    check({p, ".stat_r"}, 64'({spkt_r, sdrop_r}) | 64'(serr_r), 64'd0);
`endif
  endtask

  task automatic apply_reset(input string p);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(p);
    model_reset();
    exp_q_f.delete();
    exp_q_r.delete();
    @(negedge clk_arbit);
    din_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    #3;
    check_zero("por");
    model_reset();
    @(negedge clk_arbit);
    rst_n = 1'b1;

    // 4-beat packet to channel 2, all ready
    beat(1, 1, 0, 3'd2, 6'h3F);
    beat(1, 0, 0, 3'd2, 6'h3F);
    beat(1, 0, 0, 3'd2, 6'h3F);
    beat(1, 0, 1, 3'd2, 6'h3F);
    beat(0, 0, 0, 3'd0, 6'h3F);

    // Out-of-range destination, then destination not ready
    beat(1, 1, 0, 3'd7, 6'h3F);
    beat(1, 0, 1, 3'd7, 6'h3F);
    beat(1, 1, 0, 3'd1, 6'h3D);
    beat(1, 0, 1, 3'd1, 6'h3D);
    beat(0, 0, 0, 3'd0, 6'h3F);

    // Round robin over 6'b101010 from reset: channels 1, 3, 5, 1
    apply_reset("rst_rr");
    for (int p = 0; p < 4; p++) begin
      beat(1, 1, 0, 3'd3, 6'b101010);
      beat(1, 0, 1, 3'd3, 6'b101010);
    end
    // No channel ready at all
    beat(1, 1, 1, 3'd3, 6'h00);

    // Single-beat packet to channel 0
    beat(1, 1, 1, 3'd0, 6'h3F);
    beat(0, 0, 0, 3'd0, 6'h3F);

    // Second sop before eop, then stray beat in idle
    beat(1, 1, 0, 3'd2, 6'h3F);
    beat(1, 0, 0, 3'd2, 6'h3F);
    beat(1, 1, 0, 3'd4, 6'h3F);
    beat(1, 0, 0, 3'd4, 6'h3F);
    beat(1, 0, 1, 3'd4, 6'h3F);
    beat(1, 0, 0, 3'd4, 6'h3F);
    beat(1, 0, 1, 3'd4, 6'h3F);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      beat(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
           NC'($urandom_range(0, 63)));
    end

    // Reset in the middle of a packet; leftover beats are errors
    beat(1, 1, 0, 3'd3, 6'h3F);
    beat(1, 0, 0, 3'd3, 6'h3F);
    apply_reset("rst_mid");
    beat(1, 0, 0, 3'd3, 6'h3F);
    beat(1, 0, 1, 3'd3, 6'h3F);
    beat(1, 1, 0, 3'd3, 6'h3F);
    beat(1, 0, 1, 3'd3, 6'h3F);

    // Long packet to exercise index growth
    beat(1, 1, 0, 3'd5, 6'h3F);
    for (int i = 0; i < 20; i++) beat(1, 0, 0, 3'd5, 6'h3F);
    beat(1, 0, 1, 3'd5, 6'h3F);
    beat(0, 0, 0, 3'd0, 6'h3F);

`ifdef UTIL_DISTDEMUX_STAT_EN
    check("stat_pkt_f", 64'(spkt_f), 64'(m_pkt[0]));
    check("stat_drop_f", 64'(sdrop_f), 64'(m_drop[0]));
    check("stat_err_f", 64'(serr_f), 64'(m_errc[0]));
    check("stat_pkt_r", 64'(spkt_r), 64'(m_pkt[1]));
    check("stat_drop_r", 64'(sdrop_r), 64'(m_drop[1]));
    check("stat_err_r", 64'(serr_r), 64'(m_errc[1]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
